poisson_spike_encoder: RTL and testbench
========================================

Name: poisson_spike_encoder

Overview:
- Rate-codes a bank of input pixel intensities into spike trains for the SNN core.
- Sits directly downstream of the 16-bit LFSR.
  - Consumes the LFSR value as the random sample.
  - Drives the LFSR's shift-enable, one shift per consumed sample.
- Streams one spike decision per channel per timestep to the neuron array over a valid/ready handshake.

Parameters:
- N_CH, 16: number of input channels (pixels); at least 2.
- PIX_W, 8: pixel intensity width; 1..16.
- T_STEPS, 32: timesteps per encode run; at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pix_wr_en  input  1  write strobe into the pixel bank.
- pix_wr_addr  input  $clog2(N_CH)  pixel bank write address.
- pix_wr_data  input  PIX_W  pixel intensity.
- start  input  1  begin an encode run (pulse).
- lfsr_val  input  16  current LFSR register value.
- lfsr_shift  output  1  advance the LFSR one step.
- spike_valid  output  1  spike_ch/spike_out are valid.
- spike_ready  input  1  consumer accepts the current spike.
- spike_ch  output  $clog2(N_CH)  channel index of the current decision.
- spike_out  output  1  spike (1) / no spike (0).
- step_done  output  1  one-cycle pulse: a timestep's last channel was accepted.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse: run complete.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; pixel bank cleared to 0; channel and step counters = 0.
  - All outputs = 0.
- Random sample and spike decision:
  - rnd = lfsr_val[15:16-PIX_W] (upper PIX_W bits).
  - spike_out = (pix[spike_ch] > rnd), strict and unsigned.
  - Pixel 0 never spikes. Pixel all-ones spikes unless rnd is all-ones.
- Pixel bank:
  - Written on pix_wr_en only in IDLE.
  - Writes while busy are ignored; the bank is unchanged.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE:
    - busy=0, spike_valid=0.
    - start=1 → RUN on the next edge; ch=0, step=0, busy=1.
  - RUN:
    - spike_valid=1 while in RUN; spike_ch = ch.
    - Accept = spike_valid & spike_ready.
    - lfsr_shift = accept, combinational and same cycle; exactly one shift per accepted decision.
    - On accept with ch<N_CH-1: ch increments.
    - On accept with ch=N_CH-1: ch→0, step_done=1 for that cycle.
      - If step<T_STEPS-1: step increments.
      - Otherwise: → DONE.
  - DONE:
    - done=1 for exactly one cycle; busy=0; → IDLE.
- Stall and stability:
  - While spike_valid=1 and spike_ready=0, spike_ch and spike_out are held stable.
  - This holds because lfsr_shift=0 during the stall, so lfsr_val does not move.
- Latency:
  - start sampled in IDLE → spike_valid high on the following cycle.
  - With spike_ready held at 1: one decision per cycle; run length N_CH*T_STEPS cycles, then 1 DONE cycle.
- start during RUN or DONE is ignored; the current run is not restarted.
- Reset mid-run:
  - Immediate return to IDLE; pixel bank cleared.
  - No done or step_done pulse.
  - The LFSR is not shifted further.
- Counter widths: ch is $clog2(N_CH) bits, step is $clog2(T_STEPS)+1 bits. There is no wrap-around inside a run.

Optional Feature:
- Macro: SPIKE_CNT_EN.
- Defined:
  - Adds output spike_cnt [15:0]: total spikes accepted in the current run (accept & spike_out).
  - Cleared to 0 when start is accepted; holds its value after DONE until the next start.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset and idle: rst=0 mid-run → within 1 cycle busy=0, spike_valid=0, lfsr_shift=0. Release, then start with all pixels 0 → 0 spikes over N_CH*T_STEPS accepts.
- Threshold: pix[3]=8'h80; lfsr_val=16'h7F00 → spike_out=1 at ch 3. lfsr_val=16'h8000 → spike_out=0. pix=8'hFF with lfsr_val=16'hFFxx → spike_out=0.
- Full run with ready tied 1 (N_CH=16, T_STEPS=32):
  - 512 accepts and 512 lfsr_shift pulses.
  - 32 step_done pulses, on the ch=15 accepts.
  - done exactly one cycle after the last accept.
- Backpressure: spike_ready toggled randomly (~50%) → spike_ch/spike_out stable during stalls; lfsr_shift count equals accept count; no channel skipped or repeated.
- Ignored inputs: pix_wr_en to addr 5 with 8'hAA and a second start, both during RUN → pixel bank unchanged; run completes with the original step count.
- SPIKE_CNT_EN: all pixels 8'hFF, lfsr_val held at 16'h0000, T_STEPS=32, N_CH=16 → spike_cnt=512 at done; new start clears it to 0.

Source files
------------

// File: rtl/poisson_spike_encoder.sv
// poisson_spike_encoder
// Rate-codes a bank of pixel intensities into spike trains. Each decision
// compares one pixel against the upper PIX_W bits of an external 16-bit LFSR.
// The encoder advances the LFSR exactly once for every decision the consumer
// accepts. Decisions stream out over a valid/ready handshake, channel by
// channel, for T_STEPS timesteps.
//
// Optional feature: define SPIKE_CNT_EN to add spike_cnt[15:0]. It is a
// saturating count of the spikes accepted in the current run.
//
// state | meaning
// IDLE  | waiting for start; pixel bank writable
// RUN   | presenting one decision per channel per timestep
// DONE  | one-cycle completion pulse, then back to IDLE

module poisson_spike_encoder #(
    parameter int N_CH    = 16,
    parameter int PIX_W   = 8,
    parameter int T_STEPS = 32,
    localparam int CH_W   = $clog2(N_CH),
    localparam int STEP_W = $clog2(T_STEPS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_wr_en,
    input  logic [CH_W-1:0]   pix_wr_addr,
    input  logic [PIX_W-1:0]  pix_wr_data,
    input  logic              start,
    input  logic [15:0]       lfsr_val,
    output logic              lfsr_shift,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [CH_W-1:0]   spike_ch,
    output logic              spike_out,
    output logic              step_done,
    output logic              busy,
`ifdef SPIKE_CNT_EN
    output logic [15:0]       spike_cnt,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [STEP_W-1:0]   step;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [PIX_W-1:0]    pix [N_CH];
    logic [PIX_W-1:0]    rnd;
    logic [PIX_W-1:0]    pix_sel;
    logic                accept;
    logic                ch_last;
    logic                step_last;
    logic                unused_lfsr;

    // Only the top PIX_W bits of the LFSR take part in the decision.
    assign unused_lfsr = ^lfsr_val;
    assign rnd         = lfsr_val[15 -: PIX_W];
    assign pix_sel     = pix[ch];

    assign accept      = valid_q & spike_ready;
    assign ch_last     = (ch == CH_W'(N_CH - 1));
    assign step_last   = (step == STEP_W'(T_STEPS - 1));

    // Handshake-facing outputs. The spike decision and the LFSR shift are
    // combinational so the shift lands in the same cycle as the accept.
    // During a stall the LFSR holds, so the decision holds as well.
    assign spike_valid = valid_q;
    assign spike_ch    = ch;
    assign spike_out   = valid_q & (pix_sel > rnd);
    assign lfsr_shift  = accept;
    assign step_done   = accept & ch_last;
    assign busy        = busy_q;
    assign done        = done_q;

    // Pixel bank: cleared on reset, writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                pix[i] <= '0;
            end
        end else if ((state == IDLE) && pix_wr_en && (32'(pix_wr_addr) < N_CH)) begin
            pix[pix_wr_addr] <= pix_wr_data;
        end
    end

    // Sequencer: channel/step counters and the registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ch      <= '0;
            step    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        ch      <= '0;
                        step    <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (ch_last) begin
                            ch <= '0;
                            if (step_last) begin
                                state   <= DONE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                step <= step + 1'b1;
                            end
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPIKE_CNT_EN
    // Spikes accepted in the current run; the count is kept after DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            spike_cnt <= '0;
        end else if (accept && spike_out && (spike_cnt != 16'hFFFF)) begin
            spike_cnt <= spike_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_poisson_spike_encoder.sv
module tb_poisson_spike_encoder;
    localparam int N_CH    = 16;
    localparam int PIX_W   = 8;
    localparam int T_STEPS = 32;
    localparam int TOTAL   = N_CH * T_STEPS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_wr_en = 1'b0;
    logic [3:0]  pix_wr_addr = '0;
    logic [7:0]  pix_wr_data = '0;
    logic        start = 1'b0;
    logic [15:0] lfsr_val = '0;
    logic        lfsr_shift;
    logic        spike_valid;
    logic        spike_ready = 1'b0;
    logic [3:0]  spike_ch;
    logic        spike_out;
    logic        step_done;
    logic        busy;
    logic        done;
`ifdef SPIKE_CNT_EN
    logic [15:0] spike_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  pix_m [N_CH];
    logic [15:0] lm = 16'hACE1;
    int q[$];

    poisson_spike_encoder #(.N_CH(N_CH), .PIX_W(PIX_W), .T_STEPS(T_STEPS)) dut (
        .clk(clk), .rst(rst), .pix_wr_en(pix_wr_en), .pix_wr_addr(pix_wr_addr),
        .pix_wr_data(pix_wr_data), .start(start), .lfsr_val(lfsr_val),
        .lfsr_shift(lfsr_shift), .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spike_ch(spike_ch), .spike_out(spike_out), .step_done(step_done),
        .busy(busy),
`ifdef SPIKE_CNT_EN
        .spike_cnt(spike_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic write_pix(input int a, input logic [7:0] d);
        @(negedge clk);
        pix_wr_en = 1'b1; pix_wr_addr = 4'(a); pix_wr_data = d;
        @(posedge clk); #1;
        pix_wr_en = 1'b0;
        pix_m[a] = d;
    endtask

    // Start a run; the scoreboard receives the expected channel order.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1; spike_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        q.delete();
        for (int s = 0; s < T_STEPS; s++)
            for (int c = 0; c < N_CH; c++) q.push_back(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (spike_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", spike_valid); end
        vectors++; if (lfsr_shift !== 1'b0) begin miscompares++; $display("FAIL rst_shift got %b want 0", lfsr_shift); end
        vectors++; if (done !== 1'b0 || step_done !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got %b%b want 00", done, step_done); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N_CH; i++) pix_m[i] = 8'h00;
        q.delete();
    endtask

    task automatic test_reset();
        int spikes, shifts;
        spikes = 0; shifts = 0;
        rst = 1'b0;
        #3;
        vectors++; if ({busy, spike_valid, lfsr_shift, spike_out, step_done, done, spike_ch} !== 10'd0) begin
            miscompares++; $display("FAIL por_outputs got %b want 0", {busy, spike_valid, lfsr_shift, spike_out, step_done, done, spike_ch}); end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < N_CH; i++) pix_m[i] = 8'h00;
        for (int i = 1; i < 4; i++) write_pix(i, 8'hFF);
        do_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); spike_ready = 1'b1; lfsr_val = 16'h1234;
        end
        do_reset();
        // bank was cleared by reset: no channel may spike
        do_start();
        for (int cyc = 0; cyc < TOTAL + 20 && q.size() > 0; cyc++) begin
            @(negedge clk); spike_ready = 1'b1; lfsr_val = lm; #1;
            if (spike_valid && spike_out) spikes++;
            if (lfsr_shift) shifts++;
            void'(q.pop_front()); lm = lfsr_next(lm);
        end
        vectors++; if (spikes !== 0) begin miscompares++; $display("FAIL zero_pix_spikes got %0d want 0", spikes); end
        vectors++; if (shifts !== TOTAL) begin miscompares++; $display("FAIL zero_pix_shifts got %0d want %0d", shifts, TOTAL); end
        @(negedge clk); spike_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_threshold();
        write_pix(3, 8'h80);
        write_pix(4, 8'hFF);
        do_start();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); spike_ready = 1'b1; lfsr_val = 16'h0000;
        end
        @(negedge clk); spike_ready = 1'b0; lfsr_val = 16'h7F00; #1;
        vectors++; if (spike_ch !== 4'd3) begin miscompares++; $display("FAIL thr_ch got %0d want 3", spike_ch); end
        vectors++; if (spike_out !== 1'b1) begin miscompares++; $display("FAIL thr_80_vs_7f got %b want 1", spike_out); end
        lfsr_val = 16'h8000; #1;
        vectors++; if (spike_out !== 1'b0) begin miscompares++; $display("FAIL thr_80_vs_80 got %b want 0", spike_out); end
        @(negedge clk); spike_ready = 1'b1;
        @(negedge clk); spike_ready = 1'b0; lfsr_val = 16'hFF12; #1;
        vectors++; if (spike_ch !== 4'd4) begin miscompares++; $display("FAIL thr_ch4 got %0d want 4", spike_ch); end
        vectors++; if (spike_out !== 1'b0) begin miscompares++; $display("FAIL thr_ff_vs_ff got %b want 0", spike_out); end
        lfsr_val = 16'hFE00; #1;
        vectors++; if (spike_out !== 1'b1) begin miscompares++; $display("FAIL thr_ff_vs_fe got %b want 1", spike_out); end
        do_reset();
    endtask

    task automatic test_full_run();
        int e, sd_cnt, shifts;
        bit acc, exp_sp;
        sd_cnt = 0; shifts = 0;
        for (int i = 0; i < N_CH; i++) write_pix(i, 8'($urandom_range(0, 255)));
        do_start();
        for (int cyc = 0; cyc < TOTAL + 50; cyc++) begin
            @(negedge clk); spike_ready = 1'b1; lfsr_val = lm; #1;
            if (q.size() == 0) break;
            e = q[0]; acc = 1'b1; exp_sp = (pix_m[e] > lm[15:8]);
            vectors++; if (spike_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL full_valid_busy got %b%b want 11", spike_valid, busy); end
            vectors++; if (spike_ch !== e[3:0]) begin miscompares++; $display("FAIL full_ch got %0d want %0d", spike_ch, e); end
            vectors++; if (spike_out !== exp_sp) begin miscompares++; $display("FAIL full_spike ch%0d got %b want %b", e, spike_out, exp_sp); end
            vectors++; if (step_done !== (e == N_CH - 1)) begin miscompares++; $display("FAIL full_step_done ch%0d got %b", e, step_done); end
            if (step_done) sd_cnt++;
            if (lfsr_shift) shifts++;
            void'(q.pop_front()); if (acc) lm = lfsr_next(lm);
        end
        vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL full_timeout left %0d want 0", q.size()); end
        vectors++; if (done !== 1'b1 || busy !== 1'b0 || spike_valid !== 1'b0) begin miscompares++; $display("FAIL full_done got d%b b%b v%b want d1 b0 v0", done, busy, spike_valid); end
        vectors++; if (sd_cnt !== T_STEPS) begin miscompares++; $display("FAIL full_step_cnt got %0d want %0d", sd_cnt, T_STEPS); end
        vectors++; if (shifts !== TOTAL) begin miscompares++; $display("FAIL full_shifts got %0d want %0d", shifts, TOTAL); end
        @(negedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL full_done_width got %b want 0", done); end
        spike_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int e, shifts, accepts;
        bit acc, exp_sp, prev_stall;
        logic [3:0] prev_ch;
        logic prev_out;
        shifts = 0; accepts = 0; prev_stall = 0; prev_ch = '0; prev_out = 1'b0;
        do_start();
        for (int cyc = 0; cyc < 4 * TOTAL; cyc++) begin
            @(negedge clk); spike_ready = 1'($urandom_range(0, 1)); lfsr_val = lm; #1;
            if (q.size() == 0) break;
            e = q[0]; acc = spike_ready; exp_sp = (pix_m[e] > lm[15:8]);
            vectors++; if (spike_ch !== e[3:0]) begin miscompares++; $display("FAIL bp_ch got %0d want %0d", spike_ch, e); end
            vectors++; if (spike_out !== exp_sp) begin miscompares++; $display("FAIL bp_spike ch%0d got %b want %b", e, spike_out, exp_sp); end
            vectors++; if (lfsr_shift !== acc) begin miscompares++; $display("FAIL bp_shift got %b want %b", lfsr_shift, acc); end
            if (prev_stall) begin
                vectors++; if (spike_ch !== prev_ch || spike_out !== prev_out) begin miscompares++; $display("FAIL bp_stall_hold got %0d/%b want %0d/%b", spike_ch, spike_out, prev_ch, prev_out); end
            end
            prev_stall = !acc; prev_ch = e[3:0]; prev_out = exp_sp;
            if (lfsr_shift) shifts++;
            if (acc) begin accepts++; void'(q.pop_front()); lm = lfsr_next(lm); end
        end
        vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL bp_timeout left %0d want 0", q.size()); end
        vectors++; if (shifts !== accepts) begin miscompares++; $display("FAIL bp_shift_count got %0d want %0d", shifts, accepts); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp_done got %b want 1", done); end
        spike_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ignored();
        int e, accepts;
        bit exp_sp;
        accepts = 0;
        write_pix(5, 8'h10);
        do_start();
        for (int cyc = 0; cyc < TOTAL + 50; cyc++) begin
            @(negedge clk);
            spike_ready = 1'b1; lfsr_val = 16'h5000;
            pix_wr_en = (accepts == 40); start = (accepts == 40);
            pix_wr_addr = 4'd5; pix_wr_data = 8'hAA;
            #1;
            if (q.size() == 0) break;
            e = q[0]; exp_sp = (pix_m[e] > 8'h50);
            vectors++; if (spike_ch !== e[3:0]) begin miscompares++; $display("FAIL ign_ch got %0d want %0d", spike_ch, e); end
            vectors++; if (spike_out !== exp_sp) begin miscompares++; $display("FAIL ign_spike ch%0d got %b want %b", e, spike_out, exp_sp); end
            void'(q.pop_front()); accepts++;
        end
        pix_wr_en = 1'b0; start = 1'b0;
        vectors++; if (q.size() != 0 || accepts !== TOTAL) begin miscompares++; $display("FAIL ign_len got %0d want %0d", accepts, TOTAL); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ign_done got %b want 1", done); end
        spike_ready = 1'b0;
        @(negedge clk);
    endtask

`ifdef SPIKE_CNT_EN
    task automatic test_spike_cnt();
        for (int i = 0; i < N_CH; i++) write_pix(i, 8'hFF);
        do_start();
        for (int cyc = 0; cyc < TOTAL + 50; cyc++) begin
            @(negedge clk); spike_ready = 1'b1; lfsr_val = 16'h0000; #1;
            if (q.size() == 0) break;
            void'(q.pop_front());
        end
        vectors++; if (spike_cnt !== 16'(TOTAL)) begin miscompares++; $display("FAIL cnt_total got %0d want %0d", spike_cnt, TOTAL); end
        @(negedge clk); spike_ready = 1'b0; #1;
        vectors++; if (spike_cnt !== 16'(TOTAL)) begin miscompares++; $display("FAIL cnt_hold got %0d want %0d", spike_cnt, TOTAL); end
        do_start();
        @(negedge clk); #1;
        vectors++; if (spike_cnt !== 16'd0) begin miscompares++; $display("FAIL cnt_clear got %0d want 0", spike_cnt); end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_threshold();
        test_full_run();
        test_backpressure();
        test_ignored();
`ifdef SPIKE_CNT_EN
        test_spike_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
